display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter DWELL, default 1000: minimum cycles a grant is held before it can be taken by the other requester (>=1).
REQ-002 Parameter IDLE_VALUE, default 16'h0000: four-nibble value shown when no requester is granted.
REQ-003 Parameter BLINK_DIV, default 25_000_000: cycles per blink phase (BLINK_EN only).
REQ-004 Parameter BLANK_DIGIT, default 4'hF: nibble driven on every digit during the blink-off phase (BLINK_EN only).
REQ-005 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port req_a  input  1  requester A wants the display.
REQ-008 Port data_a  input  16  requester A value, [15:12] leftmost digit.
REQ-009 Port req_b  input  1  requester B wants the display.
REQ-010 Port data_b  input  16  requester B value, same packing.
REQ-011 Port gnt_a  output  1  A owns the display.
REQ-012 Port gnt_b  output  1  B owns the display.
REQ-013 Port dig1..dig4  output  4 each  digit codes to the four-digit driver; dig1=[15:12], dig4=[3:0].
REQ-014 Ports blink_a, blink_b  input  1 each  present only with BLINK_EN; blink request from the owner.

Function
REQ-015 FSM states: IDLE, OWN_A, OWN_B; gnt_a=1 iff OWN_A, gnt_b=1 iff OWN_B; both never high together.
REQ-016 IDLE: only one request -> grant it next edge; both -> grant the requester not in last_served; none -> stay.
REQ-017 Grant latency: exactly one cycle from request sampled high to gnt high.
REQ-018 last_served updates to the new owner on every grant edge.
REQ-019 Dwell counter clears to 0 on every grant edge, increments each owned cycle, saturates at DWELL-1.
REQ-020 Owner drops req: release next edge, regardless of dwell; go to the other owner if it requests, else IDLE.
REQ-021 Owner holds req and other requests: switch directly to the other owner (same edge drops old gnt, raises new) only once dwell counter == DWELL-1.
REQ-022 Owner holds req, other idle: stay, no time limit.
REQ-023 Display register: captures owner's data every owned cycle (registered, one cycle behind data); on the switch edge captures the new owner's data; in IDLE holds IDLE_VALUE.
REQ-024 dig1..dig4 are driven from registers only; no combinational path from inputs.

Reset
REQ-025 rst high, asynchronously: state IDLE, gnt_a=gnt_b=0, digits=IDLE_VALUE, dwell=0, last_served=B (A wins first tie), blink counter=0, phase=on.
REQ-026 rst asserted mid-grant clears immediately without waiting for a clock edge; first grant after release follows REQ-016.

Configuration
REQ-027 Macro DISPLAY_ARBITER_BLINK_EN defined: blink ports exist; phase toggles every BLINK_DIV cycles from a free-running counter; owner's blink bit high and phase off -> all digits show BLANK_DIGIT; phase not reset on grant change.
REQ-028 Macro undefined: blink ports, counter and parameters' effect absent; digits always show the display register.

Structure
REQ-029 Shared package display_pkg holds the state enumeration, the 4-bit digit type and the 16-bit four-digit value type.
REQ-030 Blink counter/phase lives in sub-module blink_timer (clk, rst, phase output), instantiated only under the macro.

Verification (bench DWELL=4, BLINK_DIV=2, IDLE_VALUE=16'h0000)
REQ-031 Reset released, no requests -> gnt 00, digits 0,0,0,0 indefinitely.
REQ-032 req_a and req_b rise same edge, data_a=16'h1234, data_b=16'h5678 -> next edge gnt_a=1, digits 1,2,3,4; after 4 owned cycles gnt_b=1, digits 5,6,7,8; A re-granted after another 4.
REQ-033 B owns, req_b drops after 1 cycle with req_a low -> IDLE, digits 0,0,0,0 next edge.
REQ-034 A owns alone, data_a changes 16'h1234 -> 16'h9ABC -> digits 9,A,B,C one edge later; grant unchanged over 20 cycles.
REQ-035 rst pulsed mid-OWN_A between clock edges -> gnt_a and digits clear immediately; after release with both requesting, A granted first.
REQ-036 BLINK_EN, A owns data 16'h1234, blink_a=1 -> digits alternate 1,2,3,4 and F,F,F,F every 2 cycles; blink_a=0 -> steady 1,2,3,4.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types for the two-requester display arbiter: FSM states and digit/value types.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } arb_state_t;

    typedef logic [3:0] digit_t;

    // Index 3 is the leftmost digit (bits [15:12]).
    typedef digit_t [3:0] quad_t;

endpackage

// File: rtl/blink_timer.sv
// Free-running blink phase generator: phase toggles every BLINK_DIV cycles (1 = blanked).
module blink_timer #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);

    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == CNT_LAST) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates a four-digit display between two requesters with a minimum grant dwell.
// Optional blinking of the owner's value is enabled by DISPLAY_ARBITER_BLINK_EN.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned DWELL       = 1000,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000,
    parameter int unsigned BLINK_DIV   = 25_000_000,
    parameter logic [3:0]  BLANK_DIGIT = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
`ifdef DISPLAY_ARBITER_BLINK_EN
    input  logic        blink_a,
    input  logic        blink_b,
`endif
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic [3:0]  dig4
);

    if (DWELL < 1 || BLINK_DIV < 1 || $bits(BLANK_DIGIT) != 4) begin : g_bad_cfg
        $error("display_arbiter: DWELL and BLINK_DIV must be at least 1");
    end

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    arb_state_t    state;
    arb_state_t    next_state;
    logic [DW-1:0] dwell;
    logic          last_b;
    logic          dwell_done;
    logic          grant_edge;
    quad_t         disp;
    quad_t         next_disp;
    quad_t         shown;

    assign dwell_done = (dwell == DWELL_LAST);
    assign grant_edge = (next_state != state) && (next_state != IDLE);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req_a && req_b)
                    next_state = last_b ? OWN_A : OWN_B;
                else if (req_a)
                    next_state = OWN_A;
                else if (req_b)
                    next_state = OWN_B;
            end
            OWN_A: begin
                if (!req_a)
                    next_state = req_b ? OWN_B : IDLE;
                else if (req_b && dwell_done)
                    next_state = OWN_B;
            end
            OWN_B: begin
                if (!req_b)
                    next_state = req_a ? OWN_A : IDLE;
                else if (req_a && dwell_done)
                    next_state = OWN_A;
            end
            default: next_state = IDLE;
        endcase
    end

    // Register the value of whoever owns the display after this edge, so a
    // switch edge already shows the new owner's data.
    always_comb begin
        next_disp = IDLE_VALUE;
        unique case (next_state)
            OWN_A:   next_disp = data_a;
            OWN_B:   next_disp = data_b;
            default: next_disp = IDLE_VALUE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            dwell  <= '0;
            last_b <= 1'b1;
            disp   <= IDLE_VALUE;
        end else begin
            state <= next_state;
            disp  <= next_disp;
            if (grant_edge) begin
                dwell  <= '0;
                last_b <= (next_state == OWN_B);
            end else if (next_state == IDLE) begin
                dwell <= '0;
            end else if (!dwell_done) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

`ifdef DISPLAY_ARBITER_BLINK_EN
    logic blink_q;
    logic phase_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= 1'b0;
        end else begin
            unique case (next_state)
                OWN_A:   blink_q <= blink_a;
                OWN_B:   blink_q <= blink_b;
                default: blink_q <= 1'b0;
            endcase
        end
    end

    blink_timer #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink_timer (
        .clk  (clk),
        .rst  (rst),
        .phase(phase_off)
    );

    assign shown = (blink_q && phase_off) ? {4{BLANK_DIGIT}} : disp;
`else
    assign shown = disp;
`endif

    assign gnt_a = (state == OWN_A);
    assign gnt_b = (state == OWN_B);
    assign dig1  = shown[3];
    assign dig2  = shown[2];
    assign dig3  = shown[1];
    assign dig4  = shown[0];

endmodule
